// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-requester dmem arbiter.
package mem_arb_pkg;

  localparam int unsigned DefAddrW = 32;
  localparam int unsigned DefSclW  = 16;
  localparam int unsigned DefVecW  = 256;
  localparam int unsigned NumReq   = 2;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StResp
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, contention goes to the
// requester that did not win last.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [NumReq-1:0] req_i,
  input  logic              last_winner_i,
  output logic              winner_o,
  output logic              valid_o
);

  always_comb begin
    valid_o = |req_i;
    if (&req_i) begin
      winner_o = ~last_winner_i;
    end else begin
      winner_o = req_i[1];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a processor and a loader onto a single dmem with scalar and vector ports.
// One access at a time: IDLE samples, ISSUE drives dmem, RESP returns read data.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned SCL_W  = DefSclW,
  parameter int unsigned VEC_W  = DefVecW
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NumReq-1:0]              req_i,
  input  logic [NumReq-1:0]              we_i,
  input  logic [NumReq-1:0]              vec_i,
  input  logic [NumReq-1:0][ADDR_W-1:0]  addr_i,
  input  logic [NumReq-1:0][VEC_W-1:0]   wdata_i,
  output logic [NumReq-1:0]              gnt_o,
  output logic [NumReq-1:0]              rvalid_o,
  output logic [VEC_W-1:0]               rdata_o,
  output logic                           mem_we,
  output logic                           mem_src_sel,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [SCL_W-1:0]               mem_wdata_a,
  output logic [VEC_W-1:0]               mem_wdata_b,
  input  logic [SCL_W-1:0]               q_a,
  input  logic [VEC_W-1:0]               q_b,
  output logic                           busy_o
);

  state_e              state_q, state_d;
  logic                last_winner_q, last_winner_d;
  logic                winner_q, winner_d;
  logic [NumReq-1:0]   gnt_q, gnt_d;
  logic [NumReq-1:0]   rvalid_q, rvalid_d;
  logic                mem_we_q, mem_we_d;
  logic                src_sel_q, src_sel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SCL_W-1:0]    wdata_a_q, wdata_a_d;
  logic [VEC_W-1:0]    wdata_b_q, wdata_b_d;

  logic arb_winner;
  logic arb_valid;

  rr_arbiter2 u_rr_arbiter2 (
    .req_i         (req_i),
    .last_winner_i (last_winner_q),
    .winner_o      (arb_winner),
    .valid_o       (arb_valid)
  );

  always_comb begin
    state_d       = state_q;
    last_winner_d = last_winner_q;
    winner_d      = winner_q;
    gnt_d         = '0;
    rvalid_d      = '0;
    mem_we_d      = 1'b0;
    src_sel_d     = src_sel_q;
    addr_d        = addr_q;
    wdata_a_d     = wdata_a_q;
    wdata_b_d     = wdata_b_q;

    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          state_d             = StIssue;
          winner_d            = arb_winner;
          last_winner_d       = arb_winner;
          gnt_d[arb_winner]   = 1'b1;
          mem_we_d            = we_i[arb_winner];
          src_sel_d           = vec_i[arb_winner];
          addr_d              = addr_i[arb_winner];
          wdata_a_d           = wdata_i[arb_winner][SCL_W-1:0];
          wdata_b_d           = wdata_i[arb_winner];
        end
      end
      StIssue: begin
        // mem_we_q still holds the latched we of the access being issued.
        if (mem_we_q) begin
          state_d = StIdle;
        end else begin
          state_d            = StResp;
          rvalid_d[winner_q] = 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      last_winner_q <= 1'b1;
      winner_q      <= 1'b0;
      gnt_q         <= '0;
      rvalid_q      <= '0;
      mem_we_q      <= 1'b0;
      src_sel_q     <= 1'b0;
      addr_q        <= '0;
      wdata_a_q     <= '0;
      wdata_b_q     <= '0;
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
      winner_q      <= winner_d;
      gnt_q         <= gnt_d;
      rvalid_q      <= rvalid_d;
      mem_we_q      <= mem_we_d;
      src_sel_q     <= src_sel_d;
      addr_q        <= addr_d;
      wdata_a_q     <= wdata_a_d;
      wdata_b_q     <= wdata_b_d;
    end
  end

  // dmem read data arrives during RESP, so it is steered straight through.
  always_comb begin
    rdata_o = '0;
    if (state_q == StResp) begin
      rdata_o = src_sel_q ? q_b : {{(VEC_W-SCL_W){1'b0}}, q_a};
    end
  end

  assign gnt_o       = gnt_q;
  assign rvalid_o    = rvalid_q;
  assign mem_we      = mem_we_q;
  assign mem_src_sel = src_sel_q;
  assign mem_addr    = addr_q;
  assign mem_wdata_a = wdata_a_q;
  assign mem_wdata_b = wdata_b_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant/response timing, width steering,
// round-robin order, busy masking and reset abort.
module tb_mem_arbiter;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        req, we, vec;
  logic [1:0][31:0]  addr;
  logic [1:0][255:0] wdata;
  logic [1:0]        gnt_o, rvalid_o;
  logic [255:0]      rdata_o;
  logic              mem_we, mem_src_sel, busy_o;
  logic [31:0]       mem_addr;
  logic [15:0]       mem_wdata_a, q_a;
  logic [255:0]      mem_wdata_b, q_b;

  int errors = 0;
  int checks = 0;

  logic [255:0] pat_a5;
  logic [255:0] beef_ext;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req),
    .we_i        (we),
    .vec_i       (vec),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .mem_we      (mem_we),
    .mem_src_sel (mem_src_sel),
    .mem_addr    (mem_addr),
    .mem_wdata_a (mem_wdata_a),
    .mem_wdata_b (mem_wdata_b),
    .q_a         (q_a),
    .q_b         (q_b),
    .busy_o      (busy_o)
  );

  // Both requesters must never be pulsed together.
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if (gnt_o === 2'b11 || rvalid_o === 2'b11) begin
        errors++;
        $display("FAIL exclusive_pulse: gnt=%b rvalid=%b required one-hot or zero", gnt_o,
                 rvalid_o);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req   = '0;
    we    = '0;
    vec   = '0;
    addr  = '0;
    wdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    #3;
    checks++;
    if ({gnt_o, rvalid_o, mem_we, mem_src_sel, busy_o} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: gnt=%b rvalid=%b we=%b sel=%b busy=%b required all 0",
               gnt_o, rvalid_o, mem_we, mem_src_sel, busy_o);
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata_a !== 16'h0 || mem_wdata_b !== 256'h0
        || rdata_o !== 256'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wa=%h wb=%h rdata=%h required 0", mem_addr,
               mem_wdata_a, mem_wdata_b, rdata_o);
    end
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (busy_o !== 1'b0 || gnt_o !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: busy=%b gnt=%b required 0 00", busy_o, gnt_o);
    end
  endtask

  task automatic test_scalar_write();
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 256'h1234;
    tick();
    checks++;
    if (gnt_o !== 2'b01 || mem_we !== 1'b1 || mem_src_sel !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL wr_issue: gnt=%b we=%b sel=%b busy=%b required 01 1 0 1", gnt_o, mem_we,
               mem_src_sel, busy_o);
    end
    checks++;
    if (mem_wdata_a !== 16'h1234 || mem_addr !== 32'h10) begin
      errors++;
      $display("FAIL wr_data: wa=%h addr=%h required 1234 00000010", mem_wdata_a, mem_addr);
    end
    idle_inputs();
    tick();
    checks++;
    if (gnt_o !== 2'b00 || rvalid_o !== 2'b00 || mem_we !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL wr_done: gnt=%b rvalid=%b we=%b busy=%b required 00 00 0 0", gnt_o,
               rvalid_o, mem_we, busy_o);
    end
    checks++;
    if (mem_addr !== 32'h10 || mem_wdata_a !== 16'h1234) begin
      errors++;
      $display("FAIL wr_hold: addr=%h wa=%h required 00000010 1234", mem_addr, mem_wdata_a);
    end
    tick();
    checks++;
    if (rvalid_o !== 2'b00) begin
      errors++;
      $display("FAIL wr_no_rvalid: rvalid=%b required 00", rvalid_o);
    end
  endtask

  task automatic test_vector_read();
    q_b = pat_a5;
    req[1] = 1'b1; vec[1] = 1'b1; addr[1] = 32'h40;
    tick();
    checks++;
    if (gnt_o !== 2'b10 || mem_src_sel !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40) begin
      errors++;
      $display("FAIL vrd_issue: gnt=%b sel=%b we=%b addr=%h required 10 1 0 00000040", gnt_o,
               mem_src_sel, mem_we, mem_addr);
    end
    idle_inputs();
    tick();
    checks++;
    if (rvalid_o !== 2'b10 || rdata_o !== pat_a5 || gnt_o !== 2'b00) begin
      errors++;
      $display("FAIL vrd_resp: rvalid=%b gnt=%b rdata=%h required 10 00 %h", rvalid_o, gnt_o,
               rdata_o, pat_a5);
    end
    tick();
    checks++;
    if (rvalid_o !== 2'b00 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL vrd_done: rvalid=%b busy=%b required 00 0", rvalid_o, busy_o);
    end
  endtask

  task automatic test_scalar_read();
    q_a = 16'hBEEF;
    q_b = pat_a5;
    req[0] = 1'b1; addr[0] = 32'h20;
    tick();
    checks++;
    if (gnt_o !== 2'b01 || mem_src_sel !== 1'b0) begin
      errors++;
      $display("FAIL srd_issue: gnt=%b sel=%b required 01 0", gnt_o, mem_src_sel);
    end
    idle_inputs();
    tick();
    checks++;
    if (rvalid_o !== 2'b01 || rdata_o !== beef_ext) begin
      errors++;
      $display("FAIL srd_resp: rvalid=%b rdata=%h required 01 %h", rvalid_o, rdata_o, beef_ext);
    end
    tick();
  endtask

  task automatic test_busy_ignore();
    req[0] = 1'b1; addr[0] = 32'h30;
    tick();
    checks++;
    if (gnt_o !== 2'b01) begin
      errors++;
      $display("FAIL bsy_gnt0: gnt=%b required 01", gnt_o);
    end
    idle_inputs();
    req[1] = 1'b1; vec[1] = 1'b1; addr[1] = 32'h50;
    tick();
    checks++;
    if (rvalid_o !== 2'b01 || gnt_o !== 2'b00) begin
      errors++;
      $display("FAIL bsy_resp: rvalid=%b gnt=%b required 01 00", rvalid_o, gnt_o);
    end
    tick();
    checks++;
    if (gnt_o !== 2'b00 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL bsy_idle: gnt=%b busy=%b required 00 0", gnt_o, busy_o);
    end
    tick();
    checks++;
    if (gnt_o !== 2'b10 || mem_addr !== 32'h50) begin
      errors++;
      $display("FAIL bsy_gnt1: gnt=%b addr=%h required 10 00000050", gnt_o, mem_addr);
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] want;
    int waited;
    idle_inputs();
    req = 2'b11; addr[0] = 32'h100; addr[1] = 32'h200;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      want = (k % 2 == 0) ? 2'b01 : 2'b10;
      waited = 0;
      while (gnt_o === 2'b00 && waited < 6) begin
        tick();
        waited++;
      end
      checks++;
      if (gnt_o !== want) begin
        errors++;
        $display("FAIL rr_order%0d: gnt=%b required %b", k, gnt_o, want);
      end
      if (k > 0) begin
        checks++;
        if (waited != 2) begin
          errors++;
          $display("FAIL rr_spacing%0d: idle cycles=%0d required 2", k, waited);
        end
      end
      tick();
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_reset_in_issue();
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h80; wdata[0] = 256'h55AA;
    tick();
    checks++;
    if (mem_we !== 1'b1 || gnt_o !== 2'b01) begin
      errors++;
      $display("FAIL rst_pre: we=%b gnt=%b required 1 01", mem_we, gnt_o);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || gnt_o !== 2'b00 || busy_o !== 1'b0 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rst_abort: we=%b gnt=%b busy=%b addr=%h required 0 00 0 0", mem_we,
               gnt_o, busy_o, mem_addr);
    end
    idle_inputs();
    tick();
    checks++;
    if (gnt_o !== 2'b00 || rvalid_o !== 2'b00 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL rst_hold: gnt=%b rvalid=%b we=%b required 00 00 0", gnt_o, rvalid_o,
               mem_we);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (busy_o !== 1'b0 || gnt_o !== 2'b00 || rvalid_o !== 2'b00) begin
      errors++;
      $display("FAIL rst_release: busy=%b gnt=%b rvalid=%b required 0 00 00", busy_o, gnt_o,
               rvalid_o);
    end
    req = 2'b11;
    tick();
    checks++;
    if (gnt_o !== 2'b01) begin
      errors++;
      $display("FAIL rst_last_winner: gnt=%b required 01", gnt_o);
    end
    idle_inputs();
    tick();
    tick();
  endtask

  initial begin
    pat_a5   = {32{8'hA5}};
    beef_ext = 256'hBEEF;
    q_a      = 16'h0;
    q_b      = 256'h0;
    reset    = 1'b0;
    idle_inputs();
    test_reset();
    test_scalar_write();
    test_vector_read();
    test_scalar_read();
    test_busy_ignore();
    test_back_to_back();
    test_reset_in_issue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
